regfile_swap: RTL
=================

REGFILE_SWAP -- requirements
Module: regfile_swap

Interface
REQ-001 Parameter: WIDTH, default 32, data bits per entry (>=1).
REQ-002 Parameter: DEPTH, default 8, number of entries (>=2, need not be a power of 2).
REQ-003 Parameter: CW, default 16, swap-counter width (>=1).
REQ-004 Derived: AW = max(1, ceil(log2(DEPTH))), address width.
REQ-005 clock  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low; low forces reset state immediately, independent of clock.
REQ-007 wr_en  in  1  write request.
REQ-008 wr_addr  in  AW  write address.
REQ-009 wr_data  in  WIDTH  write data.
REQ-010 rd_addr_a  in  AW  read port A address, also swap operand A.
REQ-011 rd_addr_b  in  AW  read port B address, also swap operand B.
REQ-012 rd_data_a  out  WIDTH  contents of entry rd_addr_a.
REQ-013 rd_data_b  out  WIDTH  contents of entry rd_addr_b.
REQ-014 swap_en  in  1  atomic exchange of entries rd_addr_a and rd_addr_b.
REQ-015 clr_start  in  1  start sequential clear of all entries.
REQ-016 busy  out  1  high while the clear sequence runs.
REQ-017 clr_done  out  1  one-cycle pulse after the clear completes.
REQ-018 swap_count  out  CW  number of effective swaps since the last reset or clear.

Function
REQ-019 Reads shall be combinational from stored state, with no write bypass: a write appears on rd_data_* in the cycle after its clock edge.
REQ-020 A read of an address >= DEPTH shall return 0.
REQ-021 In IDLE, wr_en=1 with swap_en=0 shall write wr_data to wr_addr at the clock edge; writes to addresses >= DEPTH shall be ignored.
REQ-022 In IDLE, swap_en=1 shall update in one edge: entry[a] <- old entry[b] and entry[b] <- old entry[a].
REQ-023 A swap with a == b, or with either address >= DEPTH, shall leave the array unchanged and shall not increment swap_count.
REQ-024 If swap_en and wr_en are both high, the swap shall take priority and the write shall be dropped.
REQ-025 Each effective swap shall increment swap_count by 1, saturating at 2^CW-1 (no wrap).
REQ-026 FSM states: IDLE and CLEAR.
REQ-027 IDLE -> CLEAR on clr_start=1; at that edge the clear counter shall load 0 and swap_count shall load 0.
REQ-028 In CLEAR, each cycle shall zero entry[cnt] and increment cnt.
REQ-029 The edge that clears entry DEPTH-1 shall return the FSM to IDLE; a full clear takes exactly DEPTH cycles.
REQ-030 busy shall equal (state == CLEAR).
REQ-031 clr_done shall be high for exactly the one cycle following the edge that clears the last entry.
REQ-032 clr_start, wr_en and swap_en shall be ignored while busy=1; no requests are queued.
REQ-033 Reads shall remain valid during CLEAR and reflect partially cleared contents.
REQ-034 clr_start taking effect on the same edge as a wr_en or swap_en request shall take priority, and that request shall be dropped.

Reset
REQ-035 On reset low, all entries shall be 0; state shall be IDLE; cnt shall be 0; busy, clr_done and swap_count shall be 0; rd_data_* shall therefore read 0.
REQ-036 Reset asserted mid-CLEAR shall abort the clear immediately, with no clr_done pulse.
REQ-037 After reset is released, the first rising edge shall accept requests.

Verification
REQ-038 Write 0xA5A5A5A5 to addr 3, then read A=3 on the next cycle -> rd_data_a=0xA5A5A5A5; in the same cycle as the write, rd_data_a=old value (0).
REQ-039 Load entry[1]=5 and entry[2]=9, then swap with a=1, b=2 -> next cycle rd_data_a=9, rd_data_b=5, swap_count=1; swap with a=b=4 -> no change, swap_count stays 1.
REQ-040 Issue swap_en and wr_en(addr 1, 0x77) together with a=1, b=2 -> swap is performed, 0x77 is not written.
REQ-041 With DEPTH=8 and all entries nonzero, pulse clr_start -> busy high for 8 cycles, clr_done high for 1 cycle after, all reads 0, swap_count 0; wr_en issued during busy has no effect.
REQ-042 Assert reset asynchronously (between edges) at clear cycle 3 -> all outputs 0 immediately, busy=0, and no clr_done pulse follows.
REQ-043 With CW=2, perform 5 effective swaps -> swap_count=3 (saturated); with DEPTH=5, write to addr 6 -> ignored, and a read of addr 6 returns 0.

Source files
------------

// File: rtl/regfile_swap_if.sv
// Bus bundle for regfile_swap: write port, two read/swap address ports,
// clear control and status.
//
// Handshake: there is no ready signal. A request (wr_en, swap_en,
// clr_start) is taken at a rising clock edge only when busy is low at
// that edge. Requests made while busy is high are dropped, not queued.
// At one edge clr_start wins over swap_en, and swap_en wins over wr_en.
interface regfile_swap_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 3,
   parameter int CW    = 16
);
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [AW-1:0]    rd_addr_a;
   logic [AW-1:0]    rd_addr_b;
   logic [WIDTH-1:0] rd_data_a;
   logic [WIDTH-1:0] rd_data_b;
   logic             swap_en;
   logic             clr_start;
   logic             busy;
   logic             clr_done;
   logic [CW-1:0]    swap_count;
   logic             dbg_state;   // 0 = IDLE, 1 = CLEAR

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, swap_en, clr_start,
      input  rd_data_a, rd_data_b, busy, clr_done, swap_count, dbg_state
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, swap_en, clr_start,
      output rd_data_a, rd_data_b, busy, clr_done, swap_count, dbg_state
   );
endinterface

// File: rtl/regfile_swap.sv
// Register file with one write port, two combinational read ports, an
// atomic one-edge swap of the two read-addressed entries, a saturating
// swap counter and a sequential clear that walks every entry once.
module regfile_swap #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int CW    = 16
) (
   input logic          clock,
   input logic          reset,
   regfile_swap_if.slave bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   DEPTH_V  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    cnt;
   logic [CW-1:0]    swap_cnt;
   logic             done_q;

   logic clr_take;     // clear accepted this edge
   logic clr_last;     // this edge clears the final entry
   logic swap_eff;     // swap that actually changes the array
   logic wr_take;      // write accepted this edge

   // Addresses beyond the last entry are legal to present but map to nothing.
   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < DEPTH_V;
   endfunction

   // Request decode: clear beats swap beats write, nothing is taken in CLEAR.
   always_comb begin
      clr_take = 1'b0;
      swap_eff = 1'b0;
      wr_take  = 1'b0;
      clr_last = (state == S_CLEAR) && (cnt == LAST_IDX);
      if (state == S_IDLE) begin
         if (bus.clr_start) begin
            clr_take = 1'b1;
         end else if (bus.swap_en) begin
            swap_eff = in_range(bus.rd_addr_a) && in_range(bus.rd_addr_b) &&
                       (bus.rd_addr_a != bus.rd_addr_b);
         end else if (bus.wr_en) begin
            wr_take = in_range(bus.wr_addr);
         end
      end
   end

   // Next-state logic for the IDLE/CLEAR controller.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (clr_take) state_nx = S_CLEAR;
         S_CLEAR: if (clr_last) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Storage: clear walks one entry per cycle, otherwise swap or write.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (state == S_CLEAR) begin
         mem[cnt] <= '0;
      end else if (swap_eff) begin
         mem[bus.rd_addr_a] <= mem[bus.rd_addr_b];
         mem[bus.rd_addr_b] <= mem[bus.rd_addr_a];
      end else if (wr_take) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Clear pointer: loaded at clear start, advanced through the walk.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                cnt <= '0;
      else if (clr_take)         cnt <= '0;
      else if (state == S_CLEAR) cnt <= clr_last ? '0 : cnt + AW'(1);
   end

   // Swap counter: zeroed by clear, saturates instead of wrapping.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                           swap_cnt <= '0;
      else if (clr_take)                    swap_cnt <= '0;
      else if (swap_eff && swap_cnt != '1)  swap_cnt <= swap_cnt + CW'(1);
   end

   // Completion pulse for the cycle after the final entry is cleared.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) done_q <= 1'b0;
      else        done_q <= clr_last;
   end

   // Combinational reads from stored state; out-of-range reads give zero.
   always_comb begin
      bus.rd_data_a = '0;
      bus.rd_data_b = '0;
      if (in_range(bus.rd_addr_a)) bus.rd_data_a = mem[bus.rd_addr_a];
      if (in_range(bus.rd_addr_b)) bus.rd_data_b = mem[bus.rd_addr_b];
   end

   assign bus.busy       = (state == S_CLEAR);
   assign bus.clr_done   = done_q;
   assign bus.swap_count = swap_cnt;
   assign bus.dbg_state  = (state == S_CLEAR);

endmodule
